instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer side of the IF/ID pipeline register. Owns the PC and issues one instruction-memory read at a time.
- Drives the instruction word, PC and PC+4 that IF/ID captures on every rising edge.
- IF/ID has no enable, so this block implements stalls by holding its outputs stable. It implements flushes by driving a NOP bubble.
- Redirect (taken branch/jump) arrives from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven as a bubble (sll $0,$0,0).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit: hold IF outputs unchanged this cycle
- redirect  in  1  control-flow change request, one-cycle pulse
- redirect_pc  in  32  target PC; bits [1:0] ignored and forced to 00
- imem_req  out  1  read request valid
- imem_addr  out  32  read address (word aligned)
- imem_ready  in  1  memory accepts the request this cycle when imem_req=1
- imem_rvalid  in  1  read data valid; at most one response per accepted request, latency >=1 cycle
- imem_rdata  in  32  instruction word
- IF_IN  out  32  instruction to IF/ID
- IF_PC  out  32  PC of IF_IN
- IF_PCplus4  out  32  IF_PC+4
- IF_VALID  out  1  1 = real instruction, 0 = bubble
- perf_fetched  out  32  see Optional Feature
- perf_bubbles  out  32  see Optional Feature

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=REQ, hold buffer empty.
  - IF_IN=NOP_INSTR, IF_PC=0, IF_PCplus4=0, IF_VALID=0, imem_req=0 until reset deasserts.
- Outputs are registered. Only one outstanding request is allowed.
- States: REQ, WAIT, HOLD, DISCARD.
- REQ:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1 -> WAIT; otherwise stay in REQ.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with stall=0: next cycle IF_IN=imem_rdata, IF_PC=pc, IF_PCplus4=pc+4, IF_VALID=1; pc<=pc+4; state -> REQ.
  - On imem_rvalid with stall=1: capture rdata/pc into the hold buffer; outputs unchanged; state -> HOLD.
- HOLD: when stall=0, load the hold buffer into the outputs (IF_VALID=1), pc<=pc+4, state -> REQ.
- DISCARD:
  - Waits for the stale response.
  - On imem_rvalid the data is dropped and state -> REQ.
- Bubble rule: in any cycle with stall=0, redirect=0 and no instruction being delivered, the outputs load IF_IN=NOP_INSTR and IF_VALID=0. IF_PC and IF_PCplus4 keep their values.
- stall=1 with redirect=0: all four outputs hold. The memory handshake continues, e.g. REQ may still be accepted.
- Redirect has priority over stall:
  - Next cycle the outputs become a bubble (NOP_INSTR, IF_VALID=0).
  - pc <= {redirect_pc[31:2],2'b00}; the hold buffer is cleared.
  - State after redirect:
    - REQ with imem_ready=0 -> REQ, and the next cycle's address is the new pc.
    - REQ with imem_ready=1 (old request accepted) -> DISCARD.
    - WAIT with imem_rvalid=0 -> DISCARD.
    - WAIT with imem_rvalid=1 -> response dropped, REQ.
    - HOLD -> REQ.
    - DISCARD -> DISCARD (pc updated); if imem_rvalid is also high -> REQ.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- imem_rvalid is ignored in REQ and HOLD (protocol error, no state change).

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - perf_fetched increments on each cycle the outputs load a valid instruction.
  - perf_bubbles increments on each cycle the outputs load a bubble.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: no counter registers; both ports are tied to 0.

Test Plan:
- Reset, then imem_ready=1 always and 1-cycle rvalid returning 32'h2001_0005 at 0x0 -> imem_addr=0x0, then IF_IN=32'h2001_0005, IF_PC=0, IF_PCplus4=4, IF_VALID=1; the next request is at 0x4.
- stall=1 for 3 cycles while the response for 0x8 arrives -> outputs frozen at the 0x4 instruction. On stall release, IF_PC=0x8 with the buffered word; exactly one request issued for 0xC.
- redirect=1, redirect_pc=0x0000_0103 while WAIT for 0x10 -> bubble next cycle. Late response for 0x10 is dropped. Next imem_addr=0x100, then IF_PC=0x100.
- redirect and stall together in HOLD -> bubble driven despite stall, buffer discarded, next request at the redirect target.
- RESET_PC=32'hFFFF_FFFC -> first fetch at FFFF_FFFC with IF_PCplus4=0; next imem_addr=0x0.
- Assert reset mid-WAIT -> outputs go to the reset values immediately. After release the first request is at RESET_PC; an in-flight rvalid arriving while in REQ is ignored. With IF_PERF_CNT_EN, the counters read 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory read
// at a time and drives the IF/ID pipeline register inputs.
// IF/ID captures every cycle, so stalls hold these outputs and flushes
// drive a NOP bubble.
// Optional build macro: IF_PERF_CNT_EN adds fetched/bubble counters;
// without it perf_fetched and perf_bubbles are tied to zero.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_REQ     | request pc from memory, wait for imem_ready
// S_WAIT    | request accepted, waiting for imem_rvalid
// S_HOLD    | response arrived under stall, word parked in hold buffer
// S_DISCARD | redirect overtook an accepted request, drop its response
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_IN,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCplus4,
  output logic        IF_VALID,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_if_in;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pcplus4;
  logic        r_if_valid;

  logic        w_load_live;
  logic        w_load_hold;
  logic        w_load_bubble;
  logic        w_capture_hold;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_unused_rpc_bits;

  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_redirect_pc     = {redirect_pc[31:2], 2'b00};
  assign w_unused_rpc_bits = ^redirect_pc[1:0];

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_next_state;
  end

  // next-state: redirect overrides stall; accepted-but-unanswered requests go to DISCARD
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_REQ:     if (imem_ready) w_next_state = redirect ? S_DISCARD : S_WAIT;
      S_WAIT: begin
        if (redirect)         w_next_state = imem_rvalid ? S_REQ : S_DISCARD;
        else if (imem_rvalid) w_next_state = stall ? S_HOLD : S_REQ;
      end
      S_HOLD:    if (redirect || !stall) w_next_state = S_REQ;
      S_DISCARD: if (imem_rvalid) w_next_state = S_REQ;
      default:   w_next_state = S_REQ;
    endcase
  end

  // output decode: memory request and which value the IF outputs load this cycle
  always_comb begin
    imem_req       = 1'b0;
    w_load_live    = 1'b0;
    w_load_hold    = 1'b0;
    w_capture_hold = 1'b0;
    case (r_state)
      S_REQ:  imem_req = ~reset;
      S_WAIT: begin
        w_load_live    = imem_rvalid & ~stall & ~redirect;
        w_capture_hold = imem_rvalid &  stall & ~redirect;
      end
      S_HOLD: w_load_hold = ~stall & ~redirect;
      default: ;
    endcase
    w_load_bubble = redirect | (~stall & ~w_load_live & ~w_load_hold);
  end

  assign imem_addr = r_pc;

  // PC advances only when its instruction is handed to IF/ID; redirect reloads it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_hold_instr <= NOP_INSTR;
    end else if (redirect) begin
      r_pc         <= w_redirect_pc;
      r_hold_instr <= NOP_INSTR;
    end else begin
      if (w_load_live || w_load_hold) r_pc <= w_pc_plus4;
      if (w_capture_hold) r_hold_instr <= imem_rdata;
    end
  end

  // IF/ID-facing registers: load live word, held word or bubble, otherwise hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_if_in      <= NOP_INSTR;
      r_if_pc      <= 32'd0;
      r_if_pcplus4 <= 32'd0;
      r_if_valid   <= 1'b0;
    end else if (w_load_live || w_load_hold) begin
      r_if_in      <= w_load_live ? imem_rdata : r_hold_instr;
      r_if_pc      <= r_pc;
      r_if_pcplus4 <= w_pc_plus4;
      r_if_valid   <= 1'b1;
    end else if (w_load_bubble) begin
      r_if_in      <= NOP_INSTR;
      r_if_valid   <= 1'b0;
    end
  end

  assign IF_IN      = r_if_in;
  assign IF_PC      = r_if_pc;
  assign IF_PCplus4 = r_if_pcplus4;
  assign IF_VALID   = r_if_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  // count cycles that load a real instruction or a bubble into IF/ID
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= 32'd0;
      r_perf_bubbles <= 32'd0;
    end else begin
      if (w_load_live || w_load_hold) r_perf_fetched <= r_perf_fetched + 32'd1;
      else if (w_load_bubble)         r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`else
  assign perf_fetched = 32'd0;
  assign perf_bubbles = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner
// sequences (wrap-around PC, reset mid-fetch) and a randomized run checked
// against a stream-level model of the fetch behaviour.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        stall, redirect, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, IF_VALID;
  logic [31:0] imem_addr, IF_IN, IF_PC, IF_PCplus4, perf_fetched, perf_bubbles;

  logic        b_stall, b_redirect, b_ready, b_rvalid;
  logic [31:0] b_redirect_pc, b_rdata;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_in, b_pc, b_pc4, b_pf, b_pb;

  instr_fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_IN(IF_IN), .IF_PC(IF_PC), .IF_PCplus4(IF_PCplus4), .IF_VALID(IF_VALID),
    .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(reset), .stall(b_stall), .redirect(b_redirect),
    .redirect_pc(b_redirect_pc), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(b_ready), .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .IF_IN(b_in), .IF_PC(b_pc), .IF_PCplus4(b_pc4), .IF_VALID(b_valid),
    .perf_fetched(b_pf), .perf_bubbles(b_pb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic idle_inputs();
    stall = 0; redirect = 0; redirect_pc = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    b_stall = 0; b_redirect = 0; b_redirect_pc = 0; b_ready = 0; b_rvalid = 0; b_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_if_in",   IF_IN, NOP);
    chk("rst_if_pc",   IF_PC, 32'd0);
    chk("rst_if_pc4",  IF_PCplus4, 32'd0);
    chk("rst_valid",   {31'd0, IF_VALID}, 32'd0);
    chk("rst_req",     {31'd0, imem_req}, 32'd0);
    chk("rst_perf_f",  perf_fetched, 32'd0);
    chk("rst_perf_b",  perf_bubbles, 32'd0);
    chk("rst_b_if_pc", b_pc, 32'd0);
    chk("rst_b_req",   {31'd0, b_req}, 32'd0);
    reset = 0;
  endtask

  typedef struct {
    logic        stall, redirect;
    logic [31:0] rpc;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr, e_in, e_pc, e_pc4;
    logic        e_valid;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic rdy, input logic rv, input logic [31:0] dat,
                              input logic er, input logic [31:0] ea, input logic [31:0] ei,
                              input logic [31:0] ep, input logic [31:0] ep4, input logic ev);
    vec_t v;
    v.stall = st; v.redirect = rd; v.rpc = rpc; v.ready = rdy; v.rvalid = rv; v.rdata = dat;
    v.e_req = er; v.e_addr = ea; v.e_in = ei; v.e_pc = ep; v.e_pc4 = ep4; v.e_valid = ev;
    return v;
  endfunction

  vec_t tv[25];

  localparam logic [31:0] I0 = 32'h2001_0005, I4 = 32'h1111_0004, I8 = 32'h1111_0008,
                          IC = 32'h1111_000C, I10 = 32'h1111_0010, I100 = 32'h1111_0100,
                          I104 = 32'h1111_0104, I200 = 32'h1111_0200;

  // random-phase model state
  logic [31:0] exp_pc, req_addr, acc_addr, p_in, p_pc, p_pc4;
  logic        p_valid, outstanding, accepted;
  int          lat, exp_fetch, exp_bub, delivered;

  initial begin
    //          st rd rpc      rdy rv rdata        req addr    in    pc     pc4    v
    tv[0]  = mk(0, 0, 0,         1, 0, 0,          1, 32'h0,   NOP,  32'h0,   32'h0,   0);
    tv[1]  = mk(0, 0, 0,         0, 1, I0,         0, 32'h0,   I0,   32'h0,   32'h4,   1);
    tv[2]  = mk(0, 0, 0,         1, 0, 0,          1, 32'h4,   NOP,  32'h0,   32'h4,   0);
    tv[3]  = mk(0, 0, 0,         0, 1, I4,         0, 32'h0,   I4,   32'h4,   32'h8,   1);
    tv[4]  = mk(1, 0, 0,         1, 0, 0,          1, 32'h8,   I4,   32'h4,   32'h8,   1);
    tv[5]  = mk(1, 0, 0,         0, 1, I8,         0, 32'h0,   I4,   32'h4,   32'h8,   1);
    tv[6]  = mk(1, 0, 0,         0, 0, 0,          0, 32'h0,   I4,   32'h4,   32'h8,   1);
    tv[7]  = mk(0, 0, 0,         0, 0, 0,          0, 32'h0,   I8,   32'h8,   32'hC,   1);
    tv[8]  = mk(0, 0, 0,         0, 0, 0,          1, 32'hC,   NOP,  32'h8,   32'hC,   0);
    tv[9]  = mk(0, 0, 0,         1, 0, 0,          1, 32'hC,   NOP,  32'h8,   32'hC,   0);
    tv[10] = mk(0, 0, 0,         0, 1, IC,         0, 32'h0,   IC,   32'hC,   32'h10,  1);
    tv[11] = mk(0, 0, 0,         1, 0, 0,          1, 32'h10,  NOP,  32'hC,   32'h10,  0);
    tv[12] = mk(0, 1, 32'h103,   0, 0, 0,          0, 32'h0,   NOP,  32'hC,   32'h10,  0);
    tv[13] = mk(0, 0, 0,         0, 0, 0,          0, 32'h0,   NOP,  32'hC,   32'h10,  0);
    tv[14] = mk(0, 0, 0,         0, 1, I10,        0, 32'h0,   NOP,  32'hC,   32'h10,  0);
    tv[15] = mk(0, 0, 0,         1, 0, 0,          1, 32'h100, NOP,  32'hC,   32'h10,  0);
    tv[16] = mk(0, 0, 0,         0, 1, I100,       0, 32'h0,   I100, 32'h100, 32'h104, 1);
    tv[17] = mk(1, 0, 0,         1, 0, 0,          1, 32'h104, I100, 32'h100, 32'h104, 1);
    tv[18] = mk(1, 0, 0,         0, 1, I104,       0, 32'h0,   I100, 32'h100, 32'h104, 1);
    tv[19] = mk(1, 1, 32'h200,   0, 0, 0,          0, 32'h0,   NOP,  32'h100, 32'h104, 0);
    tv[20] = mk(0, 0, 0,         1, 0, 0,          1, 32'h200, NOP,  32'h100, 32'h104, 0);
    tv[21] = mk(0, 0, 0,         0, 1, I200,       0, 32'h0,   I200, 32'h200, 32'h204, 1);
    tv[22] = mk(0, 0, 0,         0, 1, 32'hDEAD_BEEF, 1, 32'h204, NOP, 32'h200, 32'h204, 0);
    tv[23] = mk(0, 1, 32'h301,   0, 0, 0,          1, 32'h204, NOP,  32'h200, 32'h204, 0);
    tv[24] = mk(0, 0, 0,         0, 0, 0,          1, 32'h300, NOP,  32'h200, 32'h204, 0);

    // wrap-around instance: first fetch at FFFF_FFFC, PC+4 wraps to 0
    do_reset();
    b_ready = 1;
    #1;
    chk("wrap_req0",  {31'd0, b_req}, 32'd1);
    chk("wrap_addr0", b_addr, 32'hFFFF_FFFC);
    @(posedge clock); #1;
    b_ready = 0; b_rvalid = 1; b_rdata = 32'hCAFE_0001;
    @(posedge clock); #1;
    b_rvalid = 0;
    chk("wrap_in",    b_in, 32'hCAFE_0001);
    chk("wrap_pc",    b_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4",   b_pc4, 32'h0);
    chk("wrap_valid", {31'd0, b_valid}, 32'd1);
    #1;
    chk("wrap_req1",  {31'd0, b_req}, 32'd1);
    chk("wrap_addr1", b_addr, 32'h0);

    // directed vector table
    do_reset();
    for (int i = 0; i < 25; i++) begin
      stall = tv[i].stall; redirect = tv[i].redirect; redirect_pc = tv[i].rpc;
      imem_ready = tv[i].ready; imem_rvalid = tv[i].rvalid; imem_rdata = tv[i].rdata;
      #1;
      chk($sformatf("tv%0d_req", i), {31'd0, imem_req}, {31'd0, tv[i].e_req});
      if (tv[i].e_req) chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].e_addr);
      @(posedge clock); #1;
      chk($sformatf("tv%0d_in", i),    IF_IN, tv[i].e_in);
      chk($sformatf("tv%0d_pc", i),    IF_PC, tv[i].e_pc);
      chk($sformatf("tv%0d_pc4", i),   IF_PCplus4, tv[i].e_pc4);
      chk($sformatf("tv%0d_valid", i), {31'd0, IF_VALID}, {31'd0, tv[i].e_valid});
    end
    idle_inputs();

    // reset asserted mid-WAIT with a valid instruction held by stall
    do_reset();
    imem_ready = 1;
    @(posedge clock); #1;
    imem_ready = 0; imem_rvalid = 1; imem_rdata = I0;
    @(posedge clock); #1;
    chk("mw_deliver_pc4", IF_PCplus4, 32'h4);
    imem_rvalid = 0; stall = 1; imem_ready = 1;
    @(posedge clock); #1;
    chk("mw_held_valid", {31'd0, IF_VALID}, 32'd1);
    @(negedge clock);
    reset = 1;
    #1;
    chk("mw_rst_in",    IF_IN, NOP);
    chk("mw_rst_pc4",   IF_PCplus4, 32'd0);
    chk("mw_rst_valid", {31'd0, IF_VALID}, 32'd0);
    chk("mw_rst_req",   {31'd0, imem_req}, 32'd0);
    chk("mw_rst_pf",    perf_fetched, 32'd0);
    chk("mw_rst_pb",    perf_bubbles, 32'd0);
    @(posedge clock); #1;
    reset = 0; stall = 0; imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
    #1;
    chk("mw_req_after",  {31'd0, imem_req}, 32'd1);
    chk("mw_addr_after", imem_addr, 32'h0);
    @(posedge clock); #1;
    imem_rvalid = 0;
    chk("mw_stale_valid", {31'd0, IF_VALID}, 32'd0);
    chk("mw_stale_in",    IF_IN, NOP);
    chk("mw_still_req",   {31'd0, imem_req}, 32'd1);
    imem_ready = 1;
    @(posedge clock); #1;
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h3C01_1234;
    @(posedge clock); #1;
    imem_rvalid = 0;
    chk("mw_refetch_in", IF_IN, 32'h3C01_1234);
    chk("mw_refetch_pc", IF_PC, 32'h0);

    // randomized run against a stream-level model
    do_reset();
    exp_pc = 32'h0; outstanding = 0; lat = 0; req_addr = 0;
    exp_fetch = 0; exp_bub = 0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = $urandom;
      imem_ready  = $urandom_range(0, 1);
      if (outstanding && lat == 0) begin
        imem_rvalid = 1; imem_rdata = memw(req_addr);
      end else begin
        imem_rvalid = 0; imem_rdata = $urandom;
      end
      #1;
      if (imem_req) begin
        chk("rnd_one_outstanding", {31'd0, outstanding}, 32'd0);
        chk("rnd_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      end
      accepted = imem_req && imem_ready;
      acc_addr = imem_addr;
      p_in = IF_IN; p_pc = IF_PC; p_pc4 = IF_PCplus4; p_valid = IF_VALID;
      @(posedge clock); #1;
      if (imem_rvalid) outstanding = 0;
      else if (outstanding && lat > 0) lat--;
      if (accepted) begin
        outstanding = 1; req_addr = acc_addr; lat = $urandom_range(0, 2);
      end
      if (redirect) begin
        chk("rnd_redir_valid", {31'd0, IF_VALID}, 32'd0);
        chk("rnd_redir_in",    IF_IN, NOP);
        chk("rnd_redir_pc",    IF_PC, p_pc);
        chk("rnd_redir_pc4",   IF_PCplus4, p_pc4);
        exp_pc = {redirect_pc[31:2], 2'b00};
        exp_bub++;
      end else if (stall) begin
        chk("rnd_stall_in",    IF_IN, p_in);
        chk("rnd_stall_pc",    IF_PC, p_pc);
        chk("rnd_stall_pc4",   IF_PCplus4, p_pc4);
        chk("rnd_stall_valid", {31'd0, IF_VALID}, {31'd0, p_valid});
      end else if (IF_VALID) begin
        chk("rnd_pc",  IF_PC, exp_pc);
        chk("rnd_in",  IF_IN, memw(exp_pc));
        chk("rnd_pc4", IF_PCplus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        exp_fetch++;
        delivered++;
      end else begin
        chk("rnd_bub_in",  IF_IN, NOP);
        chk("rnd_bub_pc",  IF_PC, p_pc);
        chk("rnd_bub_pc4", IF_PCplus4, p_pc4);
        exp_bub++;
      end
    end
    n_tests++;
    if (delivered < 100) begin
      n_fail++;
      $display("FAIL rnd_progress: delivered %0d instructions, required at least 100", delivered);
    end
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, exp_fetch);
    chk("perf_bubbles", perf_bubbles, exp_bub);
`else
    chk("perf_fetched_tied", perf_fetched, 32'd0);
    chk("perf_bubbles_tied", perf_bubbles, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
